div_frac_ctrl: RTL and testbench

- Programmable clock-enable divider controller. Divides `clk` by an integer ratio N or a half-integer ratio N.5.
- Emits a one-cycle `tick` per output period plus a near-50% `clk_out` level, all synchronous to `clk`. No gated or inverted clocks.
- N.5 is realised by alternating period lengths N and N+1, averaging N.5 over two periods.
- Ratio changes arrive over a valid/ready config port. They are buffered and applied only at period boundaries, so downstream logic never sees a runt period.

---
 rtl/div_frac_ctrl_if.sv | 27 ++
 rtl/div_frac_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_frac_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_frac_ctrl_if.sv
// Ratio configuration port of the fractional clock-enable divider:
// valid/ready transfer of an N / N.5 ratio, plus the illegal-ratio flag.
interface div_frac_ctrl_if #(
    parameter int W = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_int;
    logic         cfg_half;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_int,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_int,
        input  cfg_half,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/div_frac_ctrl.sv
// Clock-enable divider by N or N.5 (alternating N / N+1 periods).
// Emits a tick and a near-50% level; new ratios take effect only at period boundaries.
module div_frac_ctrl #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    div_frac_ctrl_if.slave cfg,
    output logic           tick,
    output logic           clk_out,
    output logic           running,
    output logic [W-1:0]   cur_int,
    output logic           cur_half
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [W:0]   ONE   = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] MIN_N = {{(W-2){1'b0}}, 2'd2};

    state_t       state_q, state_d;
    logic [W:0]   cnt_q, cnt_d;
    logic         phase_q, phase_d;
    logic         pend_full_q, pend_full_d;
    logic [W-1:0] pend_int_q, pend_int_d;
    logic         pend_half_q, pend_half_d;
    logic [W-1:0] cur_int_q, cur_int_d;
    logic         cur_half_q, cur_half_d;
    logic         err_q, err_d;

    logic         active;
    logic         xfer;
    logic         legal;
    logic         at_end;
    logic [W:0]   len;

    // Period length is one bit wider than the ratio so N=2^W-1 with .5 cannot wrap.
    assign len    = {1'b0, cur_int_q} + {{W{1'b0}}, (cur_half_q & phase_q)};
    assign active = (state_q != IDLE);
    assign at_end = active && (cnt_q == (len - ONE));
    assign xfer   = cfg.cfg_valid && !pend_full_q;
    assign legal  = (cfg.cfg_int >= MIN_N);

    assign tick          = at_end;
    assign clk_out       = active && (cnt_q >= (len >> 1));
    assign running       = active;
    assign cur_int       = cur_int_q;
    assign cur_half      = cur_half_q;
    assign cfg.cfg_ready = !pend_full_q;
    assign cfg.cfg_err   = err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        pend_full_d = pend_full_q;
        pend_int_d  = pend_int_q;
        pend_half_d = pend_half_q;
        cur_int_d   = cur_int_q;
        cur_half_d  = cur_half_q;
        err_d       = xfer && !legal;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                if (xfer && legal) begin
                    cur_int_d  = cfg.cfg_int;
                    cur_half_d = cfg.cfg_half;
                end
                if (enable && (cur_int_q >= MIN_N)) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (at_end) begin
                    cnt_d = '0;
                    // A buffered ratio wins; otherwise a ratio arriving on this very edge is taken directly.
                    if (pend_full_q) begin
                        cur_int_d   = pend_int_q;
                        cur_half_d  = pend_half_q;
                        pend_full_d = 1'b0;
                        phase_d     = 1'b0;
                    end else if (xfer && legal) begin
                        cur_int_d  = cfg.cfg_int;
                        cur_half_d = cfg.cfg_half;
                        phase_d    = 1'b0;
                    end else begin
                        phase_d = cur_half_q & ~phase_q;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (xfer && legal) begin
                        pend_int_d  = cfg.cfg_int;
                        pend_half_d = cfg.cfg_half;
                        pend_full_d = 1'b1;
                    end
                end

                if (state_q == RUN) begin
                    if (!enable) begin
                        state_d = DRAIN;
                    end
                end else if (enable) begin
                    state_d = RUN;
                end else if (at_end) begin
                    state_d = IDLE;
                    phase_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            pend_full_q <= 1'b0;
            pend_int_q  <= '0;
            pend_half_q <= 1'b0;
            cur_int_q   <= '0;
            cur_half_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            pend_full_q <= pend_full_d;
            pend_int_q  <= pend_int_d;
            pend_half_q <= pend_half_d;
            cur_int_q   <= cur_int_d;
            cur_half_q  <= cur_half_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_div_frac_ctrl.sv
// Directed bench for div_frac_ctrl: integer and half ratios, buffered reconfig,
// illegal ratio, drain / re-enable and mid-period reset.
module tb_div_frac_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         tick;
    logic         clk_out;
    logic         running;
    logic [W-1:0] cur_int;
    logic         cur_half;

    int vec_cnt = 0;
    int err_cnt = 0;

    div_frac_ctrl_if #(.W(W)) cfg_if ();

    div_frac_ctrl #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cfg      (cfg_if.slave),
        .tick     (tick),
        .clk_out  (clk_out),
        .running  (running),
        .cur_int  (cur_int),
        .cur_half (cur_half)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [W-1:0] n, input logic half);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_int   = n;
        cfg_if.cfg_half  = half;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_int   = '0;
        cfg_if.cfg_half  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Starting at the cnt=0 cycle, walk one period; pat[c] is the expected clk_out at cnt=c.
    task automatic expect_period(input string tag, input int len, input logic [7:0] pat);
        for (int c = 0; c < len; c++) begin
            check_eq({tag, "_tick"}, {31'd0, tick}, {31'd0, (c == len - 1)});
            check_eq({tag, "_clk_out"}, {31'd0, clk_out}, {31'd0, pat[c]});
            check_eq({tag, "_running"}, {31'd0, running}, 32'd1);
            step();
        end
    endtask

    initial begin
        rst              = 1'b1;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_int   = '0;
        cfg_if.cfg_half  = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_tick", {31'd0, tick}, 32'd0);
        check_eq("rst_clk_out", {31'd0, clk_out}, 32'd0);
        check_eq("rst_running", {31'd0, running}, 32'd0);
        check_eq("rst_err", {31'd0, cfg_if.cfg_err}, 32'd0);
        check_eq("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        check_eq("rst_cur_int", {24'd0, cur_int}, 32'd0);

        // Illegal ratio in IDLE, enable with no ratio stays idle
        send_cfg(8'd0, 1'b0);
        check_eq("idle_err", {31'd0, cfg_if.cfg_err}, 32'd1);
        check_eq("idle_err_cur", {24'd0, cur_int}, 32'd0);
        enable = 1'b1;
        step();
        check_eq("idle_err_clr", {31'd0, cfg_if.cfg_err}, 32'd0);
        check_eq("idle_no_run", {31'd0, running}, 32'd0);
        enable = 1'b0;

        // N=4
        send_cfg(8'd4, 1'b0);
        check_eq("n4_cur_int", {24'd0, cur_int}, 32'd4);
        check_eq("n4_cur_half", {31'd0, cur_half}, 32'd0);
        enable = 1'b1;
        step();
        expect_period("n4_p0", 4, 8'b0000_1100);
        expect_period("n4_p1", 4, 8'b0000_1100);

        // N=3.5: lengths 3,4,3,4
        do_reset();
        send_cfg(8'd3, 1'b1);
        check_eq("n35_cur_half", {31'd0, cur_half}, 32'd1);
        enable = 1'b1;
        step();
        expect_period("n35_p0", 3, 8'b0000_0110);
        expect_period("n35_p1", 4, 8'b0000_1100);
        expect_period("n35_p2", 3, 8'b0000_0110);
        expect_period("n35_p3", 4, 8'b0000_1100);

        // Reconfig 4 -> 6 sent at cnt=1
        do_reset();
        send_cfg(8'd4, 1'b0);
        enable = 1'b1;
        step();
        check_eq("rc_c0_tick", {31'd0, tick}, 32'd0);
        step();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_int   = 8'd6;
        cfg_if.cfg_half  = 1'b0;
        step();
        cfg_if.cfg_valid = 1'b0;
        check_eq("rc_ready_low", {31'd0, cfg_if.cfg_ready}, 32'd0);
        check_eq("rc_c2_tick", {31'd0, tick}, 32'd0);
        check_eq("rc_c2_cur", {24'd0, cur_int}, 32'd4);
        step();
        check_eq("rc_c3_tick", {31'd0, tick}, 32'd1);
        check_eq("rc_c3_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step();
        check_eq("rc_new_cur", {24'd0, cur_int}, 32'd6);
        check_eq("rc_ready_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
        expect_period("rc_n6", 6, 8'b0011_1000);

        // Illegal ratio N=1 while running at N=6
        send_cfg(8'd1, 1'b0);
        check_eq("bad_err", {31'd0, cfg_if.cfg_err}, 32'd1);
        check_eq("bad_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        check_eq("bad_cur", {24'd0, cur_int}, 32'd6);
        step();
        check_eq("bad_err_clr", {31'd0, cfg_if.cfg_err}, 32'd0);
        step();
        step();
        step();
        check_eq("bad_c5_tick", {31'd0, tick}, 32'd1);
        check_eq("bad_c5_cur", {24'd0, cur_int}, 32'd6);
        step();
        check_eq("bad_c0_tick", {31'd0, tick}, 32'd0);
        check_eq("bad_c0_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

        // Drain: drop enable at cnt=1 of N=5
        do_reset();
        send_cfg(8'd5, 1'b0);
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        step();
        check_eq("dr_c2_running", {31'd0, running}, 32'd1);
        check_eq("dr_c2_tick", {31'd0, tick}, 32'd0);
        step();
        check_eq("dr_c3_tick", {31'd0, tick}, 32'd0);
        step();
        check_eq("dr_c4_tick", {31'd0, tick}, 32'd1);
        check_eq("dr_c4_clk_out", {31'd0, clk_out}, 32'd1);
        step();
        check_eq("dr_idle_running", {31'd0, running}, 32'd0);
        check_eq("dr_idle_clk_out", {31'd0, clk_out}, 32'd0);
        check_eq("dr_idle_tick", {31'd0, tick}, 32'd0);
        step();
        check_eq("dr_idle2_tick", {31'd0, tick}, 32'd0);
        check_eq("dr_idle2_cur", {24'd0, cur_int}, 32'd5);

        // Drain then re-raise enable at cnt=3: no gap
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
        check_eq("re_c4_tick", {31'd0, tick}, 32'd1);
        step();
        check_eq("re_c0_running", {31'd0, running}, 32'd1);
        expect_period("re_n5", 5, 8'b0001_1100);

        // Reset at cnt=2 of N=5
        do_reset();
        send_cfg(8'd5, 1'b0);
        enable = 1'b1;
        step();
        step();
        step();
        check_eq("mr_c2_clk_out", {31'd0, clk_out}, 32'd1);
        rst = 1'b1;
        step();
        rst    = 1'b0;
        enable = 1'b0;
        check_eq("mr_tick", {31'd0, tick}, 32'd0);
        check_eq("mr_clk_out", {31'd0, clk_out}, 32'd0);
        check_eq("mr_running", {31'd0, running}, 32'd0);
        check_eq("mr_cur_int", {24'd0, cur_int}, 32'd0);
        check_eq("mr_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        check_eq("mr_err", {31'd0, cfg_if.cfg_err}, 32'd0);
        step();
        check_eq("mr_after_tick", {31'd0, tick}, 32'd0);
        check_eq("mr_after_running", {31'd0, running}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
